// File: rtl/aes_pkg.sv
// Shared AES-CTR datapath types: block width and block byte-length encoding.
package aes_pkg;

    localparam int unsigned BLOCK_W     = 128;
    localparam int unsigned BLOCK_BYTES = 16;

    typedef logic [BLOCK_W-1:0] block_t;
    typedef logic [4:0]         blen_t;

endpackage

// File: rtl/keep_decode.sv
// Byte-keep decoder: legality of a final-word keep, its leading-ones run (min 1) and the matching byte mask.
module keep_decode
    import aes_pkg::*;
#(
    parameter int unsigned KEEP_W = 4
) (
    input  logic [KEEP_W-1:0] keep,
    output logic              legal,
    output logic [4:0]        count,
    output logic [KEEP_W-1:0] mask
);

    blen_t lead;
    logic  run;

    always_comb begin
        run   = 1'b1;
        lead  = '0;
        mask  = '0;
        for (int unsigned i = 0; i < KEEP_W; i++) begin
            if (run && keep[KEEP_W-1-i]) lead = lead + 5'd1;
            else                         run  = 1'b0;
        end
        // A keep with no leading byte still carries one byte so the block is never empty.
        count = (lead == '0) ? 5'd1 : lead;
        for (int unsigned i = 0; i < KEEP_W; i++) mask[KEEP_W-1-i] = (i < 32'(count));
        legal = (lead != '0) && (keep == mask);
    end

endmodule

// File: rtl/aes_ctr_packer.sv
// Packs a narrow keep/last word stream into big-endian 128-bit blocks for the AES-CTR core,
// with an accumulator plus output register so the input keeps flowing while the core stalls.
module aes_ctr_packer
    import aes_pkg::*;
#(
    parameter int unsigned WORD_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic [WORD_W-1:0]     s_data_i,
    input  logic [WORD_W/8-1:0]   s_keep_i,
    input  logic                  s_last_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic [127:0]          din_o,
    output logic [4:0]            din_bytes_o,
    output logic                  din_last_o,
    output logic                  din_valid_o,
    input  logic                  din_ready_i,
    output logic                  err_o
);

    localparam int unsigned KEEP_W = WORD_W / 8;
    localparam int unsigned NWORDS = BLOCK_BYTES / KEEP_W;
    localparam int unsigned IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    if (WORD_W != 8 && WORD_W != 16 && WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
        $error("aes_ctr_packer: WORD_W must be 8, 16, 32 or 64");
    end

    logic [IDX_W-1:0]  idx;
    block_t            acc;
    blen_t             acc_bytes;
    logic              acc_last;
    logic              acc_full;

    logic              dec_legal;
    logic [4:0]        dec_count;
    logic [KEEP_W-1:0] dec_mask;

    logic              accept;
    logic              done;
    logic              out_free;
    logic              bad_keep;
    logic [KEEP_W-1:0] keep_eff;
    logic [WORD_W-1:0] word_mask;
    logic [WORD_W-1:0] word_in;
    int unsigned       shamt;
    block_t            blk_next;
    blen_t             bytes_next;

    keep_decode #(
        .KEEP_W (KEEP_W)
    ) u_keep_decode (
        .keep  (s_keep_i),
        .legal (dec_legal),
        .count (dec_count),
        .mask  (dec_mask)
    );

    assign s_ready_o = ~acc_full;
    assign accept    = s_valid_i & s_ready_o & ~flush_i;
    assign done      = accept & ((idx == IDX_W'(NWORDS - 1)) | s_last_i);
    assign out_free  = ~din_valid_o | din_ready_i;

    always_comb begin
        word_mask = '0;
        // Illegal keeps are coerced: all-ones mid-message, leading-ones run on the last word.
        keep_eff  = s_last_i ? dec_mask : '1;
        bad_keep  = s_last_i ? ~dec_legal : (s_keep_i != '1);
        for (int unsigned b = 0; b < KEEP_W; b++) word_mask[b*8 +: 8] = {8{keep_eff[b]}};
        word_in    = s_data_i & word_mask;
        shamt      = 32'(idx) * WORD_W;
        blk_next   = acc | ({word_in, {(BLOCK_W-WORD_W){1'b0}}} >> shamt);
        bytes_next = blen_t'(32'(idx) * KEEP_W + (s_last_i ? 32'(dec_count) : KEEP_W));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx         <= '0;
            acc         <= '0;
            acc_bytes   <= '0;
            acc_last    <= 1'b0;
            acc_full    <= 1'b0;
            din_o       <= '0;
            din_bytes_o <= '0;
            din_last_o  <= 1'b0;
            din_valid_o <= 1'b0;
            err_o       <= 1'b0;
        end else if (flush_i) begin
            idx         <= '0;
            acc         <= '0;
            acc_bytes   <= '0;
            acc_last    <= 1'b0;
            acc_full    <= 1'b0;
            din_o       <= '0;
            din_bytes_o <= '0;
            din_last_o  <= 1'b0;
            din_valid_o <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            if (accept && bad_keep) err_o <= 1'b1;
            if (accept) idx <= done ? '0 : idx + IDX_W'(1);

            if (acc_full && out_free) begin
                // Queued block replaces the one handshaking this edge, so no bubble.
                din_o       <= acc;
                din_bytes_o <= acc_bytes;
                din_last_o  <= acc_last;
                din_valid_o <= 1'b1;
                acc         <= '0;
                acc_bytes   <= '0;
                acc_last    <= 1'b0;
                acc_full    <= 1'b0;
            end else if (done && out_free) begin
                din_o       <= blk_next;
                din_bytes_o <= bytes_next;
                din_last_o  <= s_last_i;
                din_valid_o <= 1'b1;
                acc         <= '0;
            end else begin
                if (din_valid_o && din_ready_i) din_valid_o <= 1'b0;
                if (done) begin
                    acc       <= blk_next;
                    acc_bytes <= bytes_next;
                    acc_last  <= s_last_i;
                    acc_full  <= 1'b1;
                end else if (accept) begin
                    acc <= blk_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_ctr_packer.sv
// Directed bench for aes_ctr_packer (WORD_W=32) with hand-computed expected blocks.
module tb_aes_ctr_packer;
    import aes_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush_i;
    logic [31:0]  s_data_i;
    logic [3:0]   s_keep_i;
    logic         s_last_i;
    logic         s_valid_i;
    logic         s_ready_o;
    logic [127:0] din_o;
    logic [4:0]   din_bytes_o;
    logic         din_last_o;
    logic         din_valid_o;
    logic         din_ready_i;
    logic         err_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    block_t     q_data[$];
    logic [4:0] q_bytes[$];
    logic       q_last[$];
    int         q_cyc[$];

    aes_ctr_packer #(
        .WORD_W (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .s_data_i    (s_data_i),
        .s_keep_i    (s_keep_i),
        .s_last_i    (s_last_i),
        .s_valid_i   (s_valid_i),
        .s_ready_o   (s_ready_o),
        .din_o       (din_o),
        .din_bytes_o (din_bytes_o),
        .din_last_o  (din_last_o),
        .din_valid_o (din_valid_o),
        .din_ready_i (din_ready_i),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs only change just after a rising edge, so a handshake seen here completes on the next edge.
    always @(negedge clk) begin
        if (!rst && !flush_i && din_valid_o && din_ready_i) begin
            q_data.push_back(din_o);
            q_bytes.push_back(din_bytes_o);
            q_last.push_back(din_last_o);
            q_cyc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        q_data.delete();
        q_bytes.delete();
        q_last.delete();
        q_cyc.delete();
    endtask

    task automatic send_word(input logic [31:0] data, input logic [3:0] keep, input logic last);
        logic ok;
        ok        = 1'b0;
        s_data_i  = data;
        s_keep_i  = keep;
        s_last_i  = last;
        s_valid_i = 1'b1;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (s_ready_o) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        check_eq("send_accept", {127'b0, ok}, 128'd1);
    endtask

    task automatic wait_blocks(input int n);
        for (int c = 0; c < 300 && q_data.size() < n; c++) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        block_t exp_blk;
        int     low;
        int     bad;

        rst         = 1'b1;
        flush_i     = 1'b0;
        s_data_i    = '0;
        s_keep_i    = '0;
        s_last_i    = 1'b0;
        s_valid_i   = 1'b0;
        din_ready_i = 1'b0;
        #2;
        check_eq("rst_valid", din_valid_o, 0);
        check_eq("rst_ready", s_ready_o, 1);
        check_eq("rst_err",   err_o, 0);
        check_eq("rst_din",   din_o, 0);
        check_eq("rst_bytes", din_bytes_o, 0);
        check_eq("rst_last",  din_last_o, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Four full words, last on the fourth.
        din_ready_i = 1'b1;
        send_word(32'h00112233, 4'hF, 1'b0);
        send_word(32'h44556677, 4'hF, 1'b0);
        send_word(32'h8899AABB, 4'hF, 1'b0);
        check_eq("t1_not_early", din_valid_o, 0);
        send_word(32'hCCDDEEFF, 4'hF, 1'b1);
        check_eq("t1_valid", din_valid_o, 1);
        check_eq("t1_din",   din_o, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        check_eq("t1_bytes", din_bytes_o, 16);
        check_eq("t1_last",  din_last_o, 1);
        @(posedge clk);
        #1;
        check_eq("t1_drop", din_valid_o, 0);

        // Short final block, unkept bytes must read as zero.
        send_word(32'hAABBCCDD, 4'hF, 1'b0);
        send_word(32'hEE112233, 4'h8, 1'b1);
        check_eq("t2_valid", din_valid_o, 1);
        check_eq("t2_din",   din_o, 128'hAABBCCDD_EE000000_00000000_00000000);
        check_eq("t2_bytes", din_bytes_o, 5);
        check_eq("t2_last",  din_last_o, 1);
        check_eq("t2_err",   err_o, 0);
        @(posedge clk);
        #1;

        // Core stalled while 12 words arrive.
        clear_q();
        din_ready_i = 1'b0;
        for (int i = 1; i <= 7; i++) send_word(32'(i), 4'hF, 1'b0);
        check_eq("t3_ready_7", s_ready_o, 1);
        send_word(32'd8, 4'hF, 1'b0);
        check_eq("t3_ready_8", s_ready_o, 0);
        check_eq("t3_hold_valid", din_valid_o, 1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("t3_hold_din",   din_o, 128'h00000001_00000002_00000003_00000004);
        check_eq("t3_hold_bytes", din_bytes_o, 16);
        check_eq("t3_hold_ready", s_ready_o, 0);
        fork
            begin
                for (int i = 9; i <= 12; i++) send_word(32'(i), 4'hF, 1'b0);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                din_ready_i = 1'b1;
            end
        join
        wait_blocks(3);
        check_eq("t3_count", q_data.size(), 3);
        if (q_data.size() >= 3) begin
            check_eq("t3_blk1", q_data[0], 128'h00000001_00000002_00000003_00000004);
            check_eq("t3_blk2", q_data[1], 128'h00000005_00000006_00000007_00000008);
            check_eq("t3_blk3", q_data[2], 128'h00000009_0000000A_0000000B_0000000C);
            check_eq("t3_last3", q_last[2], 0);
        end

        // Continuous streaming: 32 words, 8 blocks, one every 4 cycles.
        clear_q();
        din_ready_i = 1'b1;
        low = 0;
        for (int i = 0; i < 32; i++) begin
            s_valid_i = 1'b1;
            s_data_i  = 32'hC0DE0000 | 32'(i);
            s_keep_i  = 4'hF;
            s_last_i  = (i == 31);
            if (!s_ready_o) low++;
            @(posedge clk);
            #1;
        end
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        wait_blocks(8);
        check_eq("t4_ready_low", low, 0);
        check_eq("t4_count", q_data.size(), 8);
        bad = 0;
        for (int k = 0; k < 8 && k < q_data.size(); k++) begin
            exp_blk = '0;
            for (int j = 0; j < 4; j++) exp_blk = {exp_blk[95:0], 32'hC0DE0000 | 32'(4*k + j)};
            check_eq($sformatf("t4_blk%0d", k), q_data[k], exp_blk);
            if (k > 0 && q_cyc[k] - q_cyc[k-1] != 4) bad++;
            if (q_last[k] != (k == 7)) bad++;
        end
        check_eq("t4_timing_last", bad, 0);

        // Illegal keep mid-message, then flush with a partial block and a dropped word.
        send_word(32'hF0F0F0F0, 4'h7, 1'b0);
        send_word(32'h11111111, 4'hF, 1'b0);
        send_word(32'h22222222, 4'hF, 1'b0);
        send_word(32'h33333333, 4'hF, 1'b1);
        check_eq("t5_err",   err_o, 1);
        check_eq("t5_din",   din_o, 128'hF0F0F0F0_11111111_22222222_33333333);
        check_eq("t5_bytes", din_bytes_o, 16);
        send_word(32'h44444444, 4'hF, 1'b0);
        flush_i   = 1'b1;
        s_valid_i = 1'b1;
        s_data_i  = 32'hDEADBEEF;
        s_keep_i  = 4'hF;
        @(posedge clk);
        #1;
        flush_i   = 1'b0;
        s_valid_i = 1'b0;
        check_eq("t5_flush_err",   err_o, 0);
        check_eq("t5_flush_valid", din_valid_o, 0);
        check_eq("t5_flush_ready", s_ready_o, 1);
        clear_q();
        send_word(32'h55555555, 4'hF, 1'b0);
        send_word(32'h66666666, 4'hF, 1'b0);
        send_word(32'h77777777, 4'hF, 1'b0);
        send_word(32'h88888888, 4'hF, 1'b1);
        wait_blocks(1);
        check_eq("t5_post_count", q_data.size(), 1);
        if (q_data.size() >= 1)
            check_eq("t5_post_blk", q_data[0], 128'h55555555_66666666_77777777_88888888);

        // Illegal last-word keep with no leading byte collapses to one byte.
        send_word(32'h12345678, 4'h6, 1'b1);
        check_eq("t6_din",   din_o, 128'h12000000_00000000_00000000_00000000);
        check_eq("t6_bytes", din_bytes_o, 1);
        check_eq("t6_err",   err_o, 1);
        @(posedge clk);
        #1;

        // Asynchronous reset with a block held and a partial block in flight.
        din_ready_i = 1'b0;
        send_word(32'hA1A1A1A1, 4'hF, 1'b0);
        send_word(32'hA2A2A2A2, 4'hF, 1'b0);
        send_word(32'hA3A3A3A3, 4'hF, 1'b0);
        send_word(32'hA4A4A4A4, 4'hF, 1'b0);
        send_word(32'hB1B1B1B1, 4'hF, 1'b0);
        send_word(32'hB2B2B2B2, 4'hF, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t7_valid", din_valid_o, 0);
        check_eq("t7_din",   din_o, 0);
        check_eq("t7_bytes", din_bytes_o, 0);
        check_eq("t7_err",   err_o, 0);
        check_eq("t7_ready", s_ready_o, 1);
        @(negedge clk);
        rst = 1'b0;
        clear_q();
        din_ready_i = 1'b1;
        @(posedge clk);
        #1;
        send_word(32'hC1C1C1C1, 4'hF, 1'b0);
        send_word(32'hC2C2C2C2, 4'hF, 1'b0);
        send_word(32'hC3C3C3C3, 4'hF, 1'b0);
        send_word(32'hC4C4C4C4, 4'hF, 1'b1);
        wait_blocks(1);
        repeat (4) @(posedge clk);
        #1;
        check_eq("t7_count", q_data.size(), 1);
        if (q_data.size() >= 1) begin
            check_eq("t7_blk",  q_data[0], 128'hC1C1C1C1_C2C2C2C2_C3C3C3C3_C4C4C4C4);
            check_eq("t7_last", q_last[0], 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL tb_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
